uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Parametrised UART receiver, successor to the fixed 4-bit receiver in the CNN host link. Adds configurable data width, optional parity and 1/2 stop bits, 3-sample majority voting, false-start rejection, and frame/parity error flags. Received words are held behind a valid/ready handshake with overrun detection, so the downstream weight/command loader can stall without losing framing.

## Interface
- `c_clkfreq`, default 100_000_000: system clock frequency in Hz.
- `c_baudrate`, default 115_200: line rate; `c_bittimerlim = c_clkfreq / c_baudrate`, must be >= 8.
- `c_databits`, default 8: data bits per frame, legal range 4..8, LSB first.
- `c_parity`, default 0: 0 = none, 1 = even, 2 = odd.
- `c_stopbits`, default 1: 1 or 2.
- `clk`  in  1: single clock, rising edge.
- `rst_ni`  in  1: reset, asynchronous assert, active-low.
- `rx_i`  in  1: asynchronous serial line, idle high.
- `dout_o`  out  c_databits: received word, stable while `valid_o` is high.
- `valid_o`  out  1: word available.
- `ready_i`  in  1: consumer accepts the word when `valid_o && ready_i`.
- `parity_err_o`  out  1: parity mismatch, qualified by `valid_o`; 0 when `c_parity = 0`.
- `frame_err_o`  out  1: a stop bit was voted 0, qualified by `valid_o`.
- `overrun_o`  out  1: one-cycle pulse when a frame completes while `valid_o && !ready_i`.
- `busy_o`  out  1: high in any state other than S_IDLE.

## Operation
- `rx_i` passes through a 2-flop synchroniser (flops reset to 1). All references to rx below mean the synchronised signal.
- FSM states are S_IDLE, S_START, S_DATA, S_PARITY and S_STOP. The bit timer width is `$clog2(c_bittimerlim)`.
- **S_IDLE:** when rx = 0, clear the timer and go to S_START.
- **Voting in every non-idle state:**
  - The timer counts 0 .. `c_bittimerlim-1` per bit, with count 0 at the start of each bit.
  - Sample rx at counts h-1, h and h+1, where h = `c_bittimerlim/2`.
  - The bit value is the majority of the 3 samples, decided at count h+1.
- **S_START:** at the decision point:
  - Voted 1 (false start): return to S_IDLE with no output.
  - Voted 0: continue. At count `c_bittimerlim-1`, wrap the timer and go to S_DATA.
- **S_DATA:**
  - Shift the voted bit in, LSB first: `shreg <= {bit, shreg[c_databits-1:1]}`.
  - After bit `c_databits-1` ends, go to S_PARITY if `c_parity != 0`, else to S_STOP.
- **S_PARITY:**
  - Compute the XOR of the data bits and the voted parity bit.
  - Error condition: result is 1 for even parity, 0 for odd parity.
- **S_STOP:**
  - Each voted stop bit that is 0 sets the frame-error latch.
  - For the last stop bit, the frame completes at its decision point (count h+1), then the FSM goes to S_IDLE. It does not wait for the full bit, which allows resynchronisation on back-to-back frames.
- **On frame completion:**
  - If `valid_o` = 0, or `valid_o && ready_i` in the same cycle: load `dout_o`, `parity_err_o`, `frame_err_o` and set `valid_o` = 1.
  - Else: pulse `overrun_o`, discard the new word and keep the held word and flags.
- `valid_o` clears the cycle after `valid_o && ready_i` unless a new frame loads in that same cycle.
- **Reset (asynchronous, any time including mid-frame):**
  - State goes to S_IDLE; timer, bit counter, shreg and latches clear.
  - `dout_o` = 0, `valid_o` = 0, `parity_err_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, `busy_o` = 0.
  - A frame in progress is dropped. Reception resumes on the next falling edge after `rst_ni` deasserts.

## Timing
- Falling edge on `rx_i` to S_START: 3 cycles (2 synchroniser + 1 FSM).
- Frame length in bit periods: N = 1 + `c_databits` + (`c_parity` != 0) + `c_stopbits`.
- Falling edge to `valid_o` high: 3 + (N-1)·`c_bittimerlim` + h + 2 cycles.
- `busy_o` drops in the same cycle `valid_o` rises.
- Handshake: `dout_o` and the flags are registered, with no combinational path from `ready_i` to `dout_o`.
- Bit-time truncation error is `c_bittimerlim` rounding only. No fractional accumulation.

## Structure
- Package `uart_pkg`:
  - state enum (S_IDLE .. S_STOP);
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - function `f_bittimerlim(clkfreq, baudrate)`.
- One sub-module, `uart_bit_sampler`: synchroniser, bit timer and 3-sample majority voter. It outputs `bit_valid` (one pulse at the decision point), `bit_val` and `bit_end`. The FSM consumes those pulses.

## Test plan
Parameters: `c_clkfreq` = 1_600_000, `c_baudrate` = 100_000 (lim 16), `c_databits` = 8.
- **Basic frame:** send 0xA5 with 8N1, `ready_i` = 1 → one `valid_o` pulse, `dout_o` = 0xA5, both error flags 0, latency 3+9·16+8+2 = 157 cycles.
- **Parity:** `c_parity` = 1, send 0x03 with parity bit 1 → `parity_err_o` = 1. Resend with parity bit 0 → flag 0.
- **Glitch and false start:**
  - A 1-cycle 0-glitch inside data bit 2 of 0x00 still yields 0x00.
  - A 4-cycle low pulse on an idle line leaves `valid_o` = 0 and `busy_o` low again within 16 cycles.
- **Frame error:** stop bit driven 0 → `valid_o` with `frame_err_o` = 1. A following good 0x5A frame is received correctly.
- **Overrun:** hold `ready_i` = 0 and send 0x11 then 0x22 back-to-back → `overrun_o` pulses once and `dout_o` stays 0x11. Raise `ready_i` → `valid_o` drops the next cycle.
- **Reset mid-frame:** assert `rst_ni` = 0 during data bit 4 → all outputs 0 immediately. After release, a new 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity modes and bit-timer helper for uart_rx_frame
// Contents: state_t (receiver FSM states), PAR_* parity-mode constants,
//           f_bittimerlim() clock cycles per bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Integer truncation only; the receiver re-aligns on every start bit,
  // so the rounding error never accumulates beyond one frame.
  function automatic int f_bittimerlim(input int clkfreq, input int baudrate);
    return clkfreq / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - received-word handshake bundle between uart_rx_frame and its consumer
// Signals: dout_o (word), valid_o, ready_i, parity_err_o, frame_err_o, overrun_o.
// master: receiver side, slave: consumer side.
interface uart_rx_frame_if #(
  parameter int c_databits = 8
);

  logic [c_databits-1:0] dout_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  parity_err_o;
  logic                  frame_err_o;
  logic                  overrun_o;

  modport master (
    output dout_o, valid_o, parity_err_o, frame_err_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  dout_o, valid_o, parity_err_o, frame_err_o, overrun_o,
    output ready_i
  );

endinterface

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - rx synchroniser, per-bit timer and 3-sample majority voter
// Ports: clk, rst_ni (async, active-low), rx_i (raw line), active (FSM not idle),
//        rx (synchronised line), bit_valid (pulse at decision count h+1),
//        bit_val (voted bit, meaningful with bit_valid), bit_end (last count of the bit).
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int c_bittimerlim = 16
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic rx_i,
  input  logic active,
  output logic rx,
  output logic bit_valid,
  output logic bit_val,
  output logic bit_end
);

  localparam int TW = $clog2(c_bittimerlim);
  localparam int H  = c_bittimerlim / 2;

  localparam logic [TW-1:0] T_S0   = TW'(H - 1);
  localparam logic [TW-1:0] T_S1   = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST = TW'(c_bittimerlim - 1);

  logic          sync1;
  logic          sync2;
  logic [TW-1:0] timer;
  logic          s0;
  logic          s1;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      timer <= '0;
      s0    <= 1'b1;
      s1    <= 1'b1;
    end else begin
      sync1 <= rx_i;
      sync2 <= sync1;
      // Held at 0 while idle so count 0 coincides with the cycle the FSM enters S_START.
      if (!active || timer == T_LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (active && timer == T_S0) begin
        s0 <= sync2;
      end
      if (active && timer == T_S1) begin
        s1 <= sync2;
      end
    end
  end

  // Third sample is the live synchronised line at the decision count.
  assign rx        = sync2;
  assign bit_valid = active && (timer == T_DEC);
  assign bit_val   = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
  assign bit_end   = active && (timer == T_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - parametrised UART receiver with parity, stop-bit checks and word handshake
// Ports: clk, rst_ni (async, active-low), rx_i (serial line, idle high),
//        busy_o (FSM not idle), rx_if (master: dout_o, valid_o, ready_i,
//        parity_err_o, frame_err_o, overrun_o).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 115_200,
  parameter int c_databits = 8,
  parameter int c_parity   = PAR_NONE,
  parameter int c_stopbits = 1
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             rx_i,
  output logic             busy_o,
  uart_rx_frame_if.master  rx_if
);

  localparam int c_bittimerlim = f_bittimerlim(c_clkfreq, c_baudrate);
  localparam int BCW           = $clog2(c_databits);

  localparam logic [BCW-1:0] BC_LAST   = BCW'(c_databits - 1);
  localparam logic           STOP_LAST = 1'(c_stopbits - 1);
  localparam logic           PAR_FLIP  = (c_parity == PAR_ODD);

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic                  stop_cnt;
  logic [c_databits-1:0] shreg;
  logic                  par_err_q;
  logic                  frm_err_q;

  logic active;
  logic rx;
  logic bit_valid;
  logic bit_val;
  logic bit_end;
  logic frm_err_now;

  assign active      = (state != S_IDLE);
  // Includes the stop bit being voted this cycle, which the latch has not seen yet.
  assign frm_err_now = frm_err_q | ~bit_val;

  uart_bit_sampler #(
    .c_bittimerlim(c_bittimerlim)
  ) u_sampler (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .rx_i     (rx_i),
    .active   (active),
    .rx       (rx),
    .bit_valid(bit_valid),
    .bit_val  (bit_val),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state              <= S_IDLE;
      bit_cnt            <= '0;
      stop_cnt           <= 1'b0;
      shreg              <= '0;
      par_err_q          <= 1'b0;
      frm_err_q          <= 1'b0;
      busy_o             <= 1'b0;
      rx_if.dout_o       <= '0;
      rx_if.valid_o      <= 1'b0;
      rx_if.parity_err_o <= 1'b0;
      rx_if.frame_err_o  <= 1'b0;
      rx_if.overrun_o    <= 1'b0;
    end else begin
      rx_if.overrun_o <= 1'b0;
      if (rx_if.valid_o && rx_if.ready_i) begin
        rx_if.valid_o <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx) begin
            state     <= S_START;
            busy_o    <= 1'b1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end
        end

        S_START: begin
          if (bit_valid && bit_val) begin
            // Line back high at mid-bit: a glitch, not a start bit.
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else if (bit_end) begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_valid) begin
            shreg <= {bit_val, shreg[c_databits-1:1]};
          end
          if (bit_end) begin
            if (bit_cnt == BC_LAST) begin
              bit_cnt <= '0;
              state   <= (c_parity != PAR_NONE) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (bit_valid) begin
            par_err_q <= (^shreg) ^ bit_val ^ PAR_FLIP;
          end
          if (bit_end) begin
            state <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_valid) begin
            if (!bit_val) begin
              frm_err_q <= 1'b1;
            end
            // Finish at mid-bit of the last stop bit so a back-to-back start edge is caught.
            if (stop_cnt == STOP_LAST) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
              if (!rx_if.valid_o || rx_if.ready_i) begin
                rx_if.dout_o       <= shreg;
                rx_if.parity_err_o <= par_err_q;
                rx_if.frame_err_o  <= frm_err_now;
                rx_if.valid_o      <= 1'b1;
              end else begin
                rx_if.overrun_o <= 1'b1;
              end
            end
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed self-checking bench for uart_rx_frame (8N1 and 8E1 instances)
module tb_uart_rx_frame;

  localparam int CLKF = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int LIM  = 16;

  logic clk     = 1'b0;
  logic rst_ni  = 1'b0;
  logic tx      = 1'b1;
  logic sel_par = 1'b0;
  logic rdy     = 1'b1;
  logic rx_a;
  logic rx_p;
  logic busy_a;
  logic busy_p;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int acc_a = 0;
  int ovr_a = 0;
  int acc_p = 0;
  int t0;
  int lat;
  int base_acc;
  int base_ovr;

  logic [7:0] acc_dout  = 8'h00;
  logic       acc_pe    = 1'b0;
  logic       acc_fe    = 1'b0;
  logic [7:0] accp_dout = 8'h00;
  logic       accp_pe   = 1'b0;

  always #5 clk = ~clk;

  assign rx_a = sel_par ? 1'b1 : tx;
  assign rx_p = sel_par ? tx : 1'b1;

  uart_rx_frame_if #(.c_databits(8)) if_a ();
  uart_rx_frame_if #(.c_databits(8)) if_p ();

  assign if_a.ready_i = rdy;
  assign if_p.ready_i = 1'b1;

  uart_rx_frame #(
    .c_clkfreq (CLKF),
    .c_baudrate(BAUD),
    .c_databits(8),
    .c_parity  (0),
    .c_stopbits(1)
  ) dut (
    .clk   (clk),
    .rst_ni(rst_ni),
    .rx_i  (rx_a),
    .busy_o(busy_a),
    .rx_if (if_a)
  );

  uart_rx_frame #(
    .c_clkfreq (CLKF),
    .c_baudrate(BAUD),
    .c_databits(8),
    .c_parity  (1),
    .c_stopbits(1)
  ) dut_p (
    .clk   (clk),
    .rst_ni(rst_ni),
    .rx_i  (rx_p),
    .busy_o(busy_p),
    .rx_if (if_p)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_a.valid_o && if_a.ready_i) begin
      acc_a    = acc_a + 1;
      acc_dout = if_a.dout_o;
      acc_pe   = if_a.parity_err_o;
      acc_fe   = if_a.frame_err_o;
    end
    if (if_a.overrun_o) ovr_a = ovr_a + 1;
    if (if_p.valid_o && if_p.ready_i) begin
      acc_p     = acc_p + 1;
      accp_dout = if_p.dout_o;
      accp_pe   = if_p.parity_err_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each call starts and ends 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input bit glitch);
    tx = b;
    if (!glitch) begin
      repeat (LIM) @(posedge clk);
      #1;
    end else begin
      repeat (9) @(posedge clk);
      #1 tx = ~b;
      @(posedge clk);
      #1 tx = b;
      repeat (LIM - 10) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                            input logic stopv, input int gl_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == gl_bit));
    if (use_par) drive_bit(pbit, 1'b0);
    drive_bit(stopv, 1'b0);
    tx = 1'b1;
  endtask

  task automatic idle(input int n);
    tx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", {31'd0, if_a.valid_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_dout", {24'd0, if_a.dout_o}, 32'd0);
    check_eq("rst_flags", {29'd0, if_a.overrun_o, if_a.parity_err_o, if_a.frame_err_o}, 32'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    idle(8);

    // Basic 8N1 frame and its latency from the falling edge.
    base_acc = acc_a;
    t0  = cyc;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
      begin
        for (int i = 0; i < 170; i++) begin
          @(negedge clk);
          if (lat < 0 && if_a.valid_o) lat = cyc - t0;
        end
      end
    join
    @(posedge clk);
    #1;
    check_eq("basic_latency", lat, 32'd157);
    check_eq("basic_count", acc_a - base_acc, 32'd1);
    check_eq("basic_dout", {24'd0, acc_dout}, 32'hA5);
    check_eq("basic_pe", {31'd0, acc_pe}, 32'd0);
    check_eq("basic_fe", {31'd0, acc_fe}, 32'd0);
    check_eq("basic_busy_after", {31'd0, busy_a}, 32'd0);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right.
    sel_par = 1'b1;
    idle(4);
    base_acc = acc_p;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1);
    idle(4);
    check_eq("par_bad_count", acc_p - base_acc, 32'd1);
    check_eq("par_bad_dout", {24'd0, accp_dout}, 32'h03);
    check_eq("par_bad_pe", {31'd0, accp_pe}, 32'd1);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    check_eq("par_good_count", acc_p - base_acc, 32'd2);
    check_eq("par_good_pe", {31'd0, accp_pe}, 32'd0);
    sel_par = 1'b0;
    idle(4);

    // Single-cycle glitch inside data bit 2 is outvoted.
    base_acc = acc_a;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 2);
    idle(4);
    check_eq("glitch_count", acc_a - base_acc, 32'd1);
    check_eq("glitch_dout", {24'd0, acc_dout}, 32'h00);
    check_eq("glitch_fe", {31'd0, acc_fe}, 32'd0);

    // Four-cycle low pulse on an idle line: false start.
    base_acc = acc_a;
    tx = 1'b0;
    repeat (4) @(posedge clk);
    #1 tx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("false_busy_high", {31'd0, busy_a}, 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("false_busy_low", {31'd0, busy_a}, 32'd0);
    check_eq("false_valid", {31'd0, if_a.valid_o}, 32'd0);
    check_eq("false_count", acc_a - base_acc, 32'd0);
    @(posedge clk);
    #1;
    idle(4);

    // Stop bit driven low, then a clean frame.
    base_acc = acc_a;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    idle(40);
    check_eq("ferr_count", acc_a - base_acc, 32'd1);
    check_eq("ferr_dout", {24'd0, acc_dout}, 32'h3C);
    check_eq("ferr_fe", {31'd0, acc_fe}, 32'd1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    check_eq("after_ferr_dout", {24'd0, acc_dout}, 32'h5A);
    check_eq("after_ferr_fe", {31'd0, acc_fe}, 32'd0);

    // Overrun with the consumer stalled.
    rdy = 1'b0;
    base_acc = acc_a;
    base_ovr = ovr_a;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    check_eq("ovr_pulses", ovr_a - base_ovr, 32'd1);
    check_eq("ovr_dout_held", {24'd0, if_a.dout_o}, 32'h11);
    check_eq("ovr_valid_held", {31'd0, if_a.valid_o}, 32'd1);
    check_eq("ovr_no_accept", acc_a - base_acc, 32'd0);
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("ovr_valid_drop", {31'd0, if_a.valid_o}, 32'd0);
    check_eq("ovr_accept_dout", {24'd0, acc_dout}, 32'h11);
    @(posedge clk);
    #1;
    idle(4);

    // Asynchronous reset during data bit 4.
    fork
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1);
      begin
        repeat (88) @(posedge clk);
        #1;
        check_eq("mid_busy_before_rst", {31'd0, busy_a}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_outputs",
                 {19'd0, busy_a, if_a.valid_o, if_a.overrun_o, if_a.parity_err_o,
                  if_a.frame_err_o, if_a.dout_o}, 32'd0);
      end
    join
    rst_ni = 1'b1;
    idle(16);
    base_acc = acc_a;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    check_eq("post_rst_count", acc_a - base_acc, 32'd1);
    check_eq("post_rst_dout", {24'd0, acc_dout}, 32'h7E);
    check_eq("post_rst_fe", {31'd0, acc_fe}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
